// File: rtl/load_unit.sv
// load_unit: single-outstanding load front end that aligns the memory read,
// waits for data or a timeout, and returns the extended field to writeback.
module load_unit #(
   parameter int ADDR_W  = 32,
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   input  logic [4:0]        req_rd,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_data,
   output logic [4:0]        resp_rd,
   output logic              resp_err,
   output logic              busy
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    f3_q, off_q;
   logic [XLEN-1:0] sh, ext;
   logic          sx, bad;
   assign req_ready = ARESETn && state == IDLE;
   always_comb begin
      sh  = mem_rdata >> {off_q, 3'b000};
      sx  = ~f3_q[2];
      ext = f3_q[1:0] == 2'b00 ? {{(XLEN-8){sx & sh[7]}}, sh[7:0]} :
            f3_q[1:0] == 2'b01 ? {{(XLEN-16){sx & sh[15]}}, sh[15:0]} :
            f3_q[1:0] == 2'b10 ? {{(XLEN-32){sx & sh[31]}}, sh[31:0]} : sh;
      bad = req_funct3 == 3'b111 ||
            (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3[1:0] == 2'b10 && |req_addr[1:0]) ||
            (req_funct3[1:0] == 2'b11 && |req_addr[2:0]);
   end
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state      <= IDLE;
         cnt        <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         mem_en     <= 1'b0;
         mem_addr   <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_rd    <= '0;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               f3_q    <= req_funct3;
               off_q   <= req_addr[2:0];
               resp_rd <= req_rd;
               busy    <= 1'b1;
               if (bad) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_data  <= '0;
               end else begin
                  state    <= MEM;
                  mem_en   <= 1'b1;
                  mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
                  cnt      <= '0;
               end
            end
            MEM: begin
               cnt <= cnt + 1'b1;
               // data arriving on the last permitted cycle still counts as success
               if (mem_valid || cnt == CW'(TIMEOUT - 1)) begin
                  state      <= RESP;
                  mem_en     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= !mem_valid;
                  resp_data  <= mem_valid ? ext : '0;
               end
            end
            RESP: if (resp_ready) begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed load sequence with a response scoreboard.
module tb_load_unit;
   localparam int TO = 4;
   logic        ACLK = 1'b0, ARESETn = 1'b0;
   logic        req_valid = 1'b0, req_ready;
   logic [31:0] req_addr = '0;
   logic [2:0]  req_funct3 = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_en, mem_valid = 1'b0;
   logic [31:0] mem_addr;
   logic [63:0] mem_rdata = '0;
   logic        resp_valid, resp_ready = 1'b0;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err, busy;
   typedef struct {logic [63:0] data; logic [4:0] rd; logic err;} exp_t;
   exp_t sb[$];
   int n_vec = 0, n_err = 0;

   load_unit #(.ADDR_W(32), .XLEN(64), .TIMEOUT(TO)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_funct3(req_funct3), .req_rd(req_rd),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_err(resp_err), .busy(busy)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // lat: mem_en cycle in which mem_valid is driven (0 = never); hold: cycles resp_ready stays low
   task automatic load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] rdata, input int lat, input int en_exp, input int hold,
                       input logic [63:0] exp_data, input logic exp_err);
      exp_t e;
      int   n = 0;
      @(negedge ACLK);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_addr = a; req_funct3 = f3; req_rd = rd;
      e.data = exp_data; e.rd = rd; e.err = exp_err;
      sb.push_back(e);
      @(negedge ACLK);
      req_valid = 1'b0;
      chk("req_ready_after_accept", req_ready, 0);
      while (mem_en && n < 300) begin
         chk("mem_addr", mem_addr, {a[31:3], 3'b000});
         n++;
         mem_valid = (n == lat);
         mem_rdata = rdata;
         @(negedge ACLK);
      end
      mem_valid = 1'b0;
      chk("mem_en_cycles", 64'(n), 64'(en_exp));
      chk("resp_valid_latency", resp_valid, 1);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_addr = 32'h80000000; req_funct3 = 3'b011;
         chk("bp_resp_valid", resp_valid, 1);
         chk("bp_resp_data", resp_data, exp_data);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_busy", busy, 1);
         @(negedge ACLK);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      chk("hs_resp_valid", resp_valid, 1);
      if (sb.size() == 0) chk("sb_nonempty", 0, 1);
      else begin
         e = sb.pop_front();
         chk("resp_data", resp_data, e.data);
         chk("resp_rd", 64'(resp_rd), 64'(e.rd));
         chk("resp_err", resp_err, e.err);
      end
      @(negedge ACLK);
      resp_ready = 1'b0;
      chk("post_resp_valid", resp_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_req_ready", req_ready, 1);
   endtask

   initial begin
      repeat (2) @(negedge ACLK);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_rd", 64'(resp_rd), 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_busy", busy, 0);
      ARESETn = 1'b1;
      load(32'h80000008, 3'b011, 5'd1, 64'h1122334455667788, 3, 3, 0, 64'h1122334455667788, 0);
      load(32'h80000005, 3'b000, 5'd2, 64'h0000F00000000000, 1, 1, 0, 64'hFFFFFFFFFFFFFFF0, 0);
      load(32'h80000005, 3'b100, 5'd3, 64'h0000F00000000000, 2, 2, 0, 64'h00000000000000F0, 0);
      load(32'h80000004, 3'b010, 5'd4, 64'h8765432100000000, 1, 1, 0, 64'hFFFFFFFF87654321, 0);
      load(32'h80000004, 3'b110, 5'd5, 64'h8765432100000000, 1, 1, 0, 64'h0000000087654321, 0);
      load(32'h80000006, 3'b001, 5'd6, 64'h7FFF000000000000, 1, 1, 0, 64'h0000000000007FFF, 0);
      load(32'h80000006, 3'b101, 5'd7, 64'h8001000000000000, 1, 1, 0, 64'h0000000000008001, 0);
      load(32'h80000003, 3'b001, 5'd8, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0, 64'h0, 1);
      load(32'h80000000, 3'b111, 5'd9, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0, 64'h0, 1);
      load(32'h80000002, 3'b010, 5'd10, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0, 64'h0, 1);
      load(32'h80000010, 3'b011, 5'd11, 64'hCAFEBABEDEADBEEF, 2, 2, 4, 64'hCAFEBABEDEADBEEF, 0);
      load(32'h80000020, 3'b011, 5'd12, 64'h1234, 0, TO, 0, 64'h0, 1);
      load(32'h80000020, 3'b011, 5'd13, 64'h00000000000000AB, TO, TO, 0, 64'h00000000000000AB, 0);
      // abandon a transaction with reset while in MEM
      @(negedge ACLK);
      req_valid = 1'b1; req_addr = 32'h80000040; req_funct3 = 3'b011; req_rd = 5'd14;
      @(negedge ACLK);
      req_valid = 1'b0;
      chk("rst_mid_mem_en_before", mem_en, 1);
      @(negedge ACLK);
      ARESETn = 1'b0;
      @(negedge ACLK);
      chk("rst_mid_mem_en", mem_en, 0);
      chk("rst_mid_resp_valid", resp_valid, 0);
      chk("rst_mid_req_ready", req_ready, 0);
      ARESETn = 1'b1;
      mem_valid = 1'b1; mem_rdata = 64'h5555;
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         chk("rst_mid_req_ready_rel", req_ready, 1);
         chk("rst_mid_no_resp", resp_valid, 0);
         chk("rst_mid_no_mem", mem_en, 0);
      end
      mem_valid = 1'b0;
      load(32'h80000001, 3'b100, 5'd15, 64'h000000000000A500, 1, 1, 0, 64'h00000000000000A5, 0);
      chk("sb_drained", 64'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
